// File: rtl/predicate_read_sequencer_pkg.sv
// rtl/predicate_read_sequencer_pkg.sv - shared sizes, types and FSM states for the predicate read sequencer
package predicate_read_sequencer_pkg;
  localparam int NUM_LANES = 16;
  localparam int NUM_PREGS = 64;
  localparam int NUM_WARPS = 8;
  localparam int TAG_W     = 4;
  localparam int ADDR_W    = $clog2(NUM_PREGS);
  localparam int WARP_W    = $clog2(NUM_WARPS);

  typedef logic [NUM_LANES-1:0] lane_mask_t;
  typedef logic [ADDR_W-1:0]    pred_addr_t;
  typedef logic [WARP_W-1:0]    warp_id_t;
  typedef logic [TAG_W-1:0]     tag_t;

  typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} seq_state_e;
endpackage

// File: rtl/predicate_read_sequencer_if.sv
// rtl/predicate_read_sequencer_if.sv - request, register-block read/snoop and response signals
interface predicate_read_sequencer_if;
  import predicate_read_sequencer_pkg::*;

  logic       req_valid;
  logic       req_ready;
  warp_id_t   req_warp;
  pred_addr_t req_addr_0;
  pred_addr_t req_addr_1;
  lane_mask_t req_lane_mask;
  tag_t       req_tag;

  lane_mask_t read_en_0;
  lane_mask_t read_en_1;
  pred_addr_t raddr_0;
  pred_addr_t raddr_1;
  warp_id_t   warp_selector;
  lane_mask_t rdata_0;
  lane_mask_t rdata_1;

  lane_mask_t wr_en;
  warp_id_t   wr_warp;
  pred_addr_t wr_addr;
  lane_mask_t wr_data;

  logic       rsp_valid;
  logic       rsp_ready;
  lane_mask_t rsp_mask_0;
  lane_mask_t rsp_mask_1;
  tag_t       rsp_tag;

  modport slave (
    input  req_valid, req_warp, req_addr_0, req_addr_1, req_lane_mask, req_tag,
    input  rdata_0, rdata_1, wr_en, wr_warp, wr_addr, wr_data, rsp_ready,
    output req_ready, read_en_0, read_en_1, raddr_0, raddr_1, warp_selector,
    output rsp_valid, rsp_mask_0, rsp_mask_1, rsp_tag
  );

  modport master (
    output req_valid, req_warp, req_addr_0, req_addr_1, req_lane_mask, req_tag,
    output rdata_0, rdata_1, wr_en, wr_warp, wr_addr, wr_data, rsp_ready,
    input  req_ready, read_en_0, read_en_1, raddr_0, raddr_1, warp_selector,
    input  rsp_valid, rsp_mask_0, rsp_mask_1, rsp_tag
  );
endinterface

// File: rtl/predicate_read_sequencer_bypass_mux.sv
// rtl/predicate_read_sequencer_bypass_mux.sv - per-lane write-first forwarding and lane masking for one read port
module predicate_read_sequencer_bypass_mux
  import predicate_read_sequencer_pkg::*;
(
  input  lane_mask_t rdata,
  input  lane_mask_t wr_en,
  input  warp_id_t   wr_warp,
  input  pred_addr_t wr_addr,
  input  lane_mask_t wr_data,
  input  warp_id_t   warp,
  input  pred_addr_t addr,
  input  lane_mask_t lane_mask,
  output lane_mask_t mask
);
  logic       hit;
  lane_mask_t fwd;

  assign hit  = (wr_warp == warp) && (wr_addr == addr);
  assign fwd  = wr_en & {NUM_LANES{hit}};
  assign mask = lane_mask & ((fwd & wr_data) | (~fwd & rdata));
endmodule

// File: rtl/predicate_read_sequencer.sv
// rtl/predicate_read_sequencer.sv - accepts a predicate-read request, drives both read ports, returns forwarded masks
module predicate_read_sequencer
  import predicate_read_sequencer_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input logic                        clk,
  input logic                        rst,
  predicate_read_sequencer_if.slave  bus
);
  seq_state_e state;
  seq_state_e state_next;
  logic       started;
  logic       ready;
  logic       accept;
  logic       capture;

  warp_id_t   lat_warp;
  pred_addr_t lat_addr_0;
  pred_addr_t lat_addr_1;
  lane_mask_t lat_mask;
  tag_t       lat_tag;

  lane_mask_t cap_mask_0;
  lane_mask_t cap_mask_1;
  lane_mask_t rsp_mask_0_q;
  lane_mask_t rsp_mask_1_q;

  // started keeps req_ready low until the first edge after reset releases
  assign ready   = started && (state == IDLE);
  assign accept  = bus.req_valid && ready;
  assign capture = (RD_LAT == 0) ? (state == READ) : (state == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      started <= 1'b0;
    end else begin
      state   <= state_next;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = READ;
      READ: state_next = (RD_LAT == 0) ? RESP : WAIT;
      WAIT: state_next = RESP;
      RESP: if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready     = ready;
    bus.read_en_0     = '0;
    bus.read_en_1     = '0;
    bus.raddr_0       = lat_addr_0;
    bus.raddr_1       = lat_addr_1;
    bus.warp_selector = lat_warp;
    bus.rsp_valid     = (state == RESP);
    bus.rsp_mask_0    = rsp_mask_0_q;
    bus.rsp_mask_1    = rsp_mask_1_q;
    bus.rsp_tag       = lat_tag;
    if (state == READ) begin
      bus.read_en_0 = lat_mask;
      bus.read_en_1 = lat_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_warp     <= '0;
      lat_addr_0   <= '0;
      lat_addr_1   <= '0;
      lat_mask     <= '0;
      lat_tag      <= '0;
      rsp_mask_0_q <= '0;
      rsp_mask_1_q <= '0;
    end else begin
      if (accept) begin
        lat_warp   <= bus.req_warp;
        lat_addr_0 <= bus.req_addr_0;
        lat_addr_1 <= bus.req_addr_1;
        lat_mask   <= bus.req_lane_mask;
        lat_tag    <= bus.req_tag;
      end
      // response is a snapshot; later writes never reach it
      if (capture) begin
        rsp_mask_0_q <= cap_mask_0;
        rsp_mask_1_q <= cap_mask_1;
      end
    end
  end

  predicate_read_sequencer_bypass_mux u_bypass_0 (
    .rdata     (bus.rdata_0),
    .wr_en     (bus.wr_en),
    .wr_warp   (bus.wr_warp),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .warp      (lat_warp),
    .addr      (lat_addr_0),
    .lane_mask (lat_mask),
    .mask      (cap_mask_0)
  );

  predicate_read_sequencer_bypass_mux u_bypass_1 (
    .rdata     (bus.rdata_1),
    .wr_en     (bus.wr_en),
    .wr_warp   (bus.wr_warp),
    .wr_addr   (bus.wr_addr),
    .wr_data   (bus.wr_data),
    .warp      (lat_warp),
    .addr      (lat_addr_1),
    .lane_mask (lat_mask),
    .mask      (cap_mask_1)
  );
endmodule

// File: tb/tb_predicate_read_sequencer.sv
// tb/tb_predicate_read_sequencer.sv - directed self-checking bench with a register-block model, RD_LAT 1 and 0
module tb_predicate_read_sequencer;
  import predicate_read_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b1;
  logic       req_valid = 1'b0;
  warp_id_t   req_warp = '0;
  pred_addr_t req_addr_0 = '0;
  pred_addr_t req_addr_1 = '0;
  lane_mask_t req_lane_mask = '0;
  tag_t       req_tag = '0;
  logic       rsp_ready = 1'b1;
  lane_mask_t wr_en = '0;
  warp_id_t   wr_warp = '0;
  pred_addr_t wr_addr = '0;
  lane_mask_t wr_data = '0;

  int vectors = 0;
  int miscompares = 0;

  lane_mask_t mem [NUM_WARPS][NUM_PREGS];
  lane_mask_t rd1_0, rd1_1;

  predicate_read_sequencer_if bus1 ();
  predicate_read_sequencer_if bus0 ();

  predicate_read_sequencer #(.RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  predicate_read_sequencer #(.RD_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  always #5 clk = ~clk;

  assign bus1.req_valid     = req_valid & sel;
  assign bus0.req_valid     = req_valid & ~sel;
  assign bus1.req_warp      = req_warp;
  assign bus0.req_warp      = req_warp;
  assign bus1.req_addr_0    = req_addr_0;
  assign bus0.req_addr_0    = req_addr_0;
  assign bus1.req_addr_1    = req_addr_1;
  assign bus0.req_addr_1    = req_addr_1;
  assign bus1.req_lane_mask = req_lane_mask;
  assign bus0.req_lane_mask = req_lane_mask;
  assign bus1.req_tag       = req_tag;
  assign bus0.req_tag       = req_tag;
  assign bus1.rsp_ready     = rsp_ready;
  assign bus0.rsp_ready     = rsp_ready;
  assign bus1.wr_en         = wr_en;
  assign bus0.wr_en         = wr_en;
  assign bus1.wr_warp       = wr_warp;
  assign bus0.wr_warp       = wr_warp;
  assign bus1.wr_addr       = wr_addr;
  assign bus0.wr_addr       = wr_addr;
  assign bus1.wr_data       = wr_data;
  assign bus0.wr_data       = wr_data;

  // register block: registered read for RD_LAT=1, combinational for RD_LAT=0
  assign bus1.rdata_0 = rd1_0;
  assign bus1.rdata_1 = rd1_1;
  assign bus0.rdata_0 = mem[bus0.warp_selector][bus0.raddr_0] & bus0.read_en_0;
  assign bus0.rdata_1 = mem[bus0.warp_selector][bus0.raddr_1] & bus0.read_en_1;

  always @(posedge clk) begin
    if (bus1.read_en_0 != '0) rd1_0 <= mem[bus1.warp_selector][bus1.raddr_0] & bus1.read_en_0;
    if (bus1.read_en_1 != '0) rd1_1 <= mem[bus1.warp_selector][bus1.raddr_1] & bus1.read_en_1;
    if (wr_en != '0)
      mem[wr_warp][wr_addr] <= (mem[wr_warp][wr_addr] & ~wr_en) | (wr_data & wr_en);
  end

  logic       cur_req_ready, cur_rsp_valid;
  lane_mask_t cur_mask_0, cur_mask_1;
  tag_t       cur_tag;
  assign cur_req_ready = sel ? bus1.req_ready  : bus0.req_ready;
  assign cur_rsp_valid = sel ? bus1.rsp_valid  : bus0.rsp_valid;
  assign cur_mask_0    = sel ? bus1.rsp_mask_0 : bus0.rsp_mask_0;
  assign cur_mask_1    = sel ? bus1.rsp_mask_1 : bus0.rsp_mask_1;
  assign cur_tag       = sel ? bus1.rsp_tag    : bus0.rsp_tag;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input int w, input int a, input lane_mask_t d);
    wr_warp = w[WARP_W-1:0];
    wr_addr = a[ADDR_W-1:0];
    wr_data = d;
    wr_en   = '1;
    tick();
    wr_en   = '0;
  endtask

  task automatic issue(input int w, input int a0, input int a1, input lane_mask_t m, input int t);
    int n;
    req_warp      = w[WARP_W-1:0];
    req_addr_0    = a0[ADDR_W-1:0];
    req_addr_1    = a1[ADDR_W-1:0];
    req_lane_mask = m;
    req_tag       = t[TAG_W-1:0];
    req_valid     = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cur_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < 20), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output lane_mask_t m0, output lane_mask_t m1, output tag_t t);
    int n;
    n = 0;
    @(negedge clk);
    while (!cur_rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rsp_wait", 32'(n < 10), 32'd1);
    m0 = cur_mask_0;
    m1 = cur_mask_1;
    t  = cur_tag;
    tick();
  endtask

  function automatic lane_mask_t pat(input int w, input int a);
    pat = {w[2:0], a[5:0], w[2:0], a[3:0]};
  endfunction

  initial begin
    lane_mask_t m0, m1;
    tag_t       t;

    // reset held with a request pending: nothing may be accepted
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_req_ready", 32'(bus1.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
      check("rst_read_en", 32'({bus1.read_en_0, bus1.read_en_1}), 32'd0);
      check("rst_addr_warp", 32'({bus1.raddr_0, bus1.raddr_1, bus1.warp_selector}), 32'd0);
      check("rst_rsp_regs", 32'({bus1.rsp_mask_0, bus1.rsp_mask_1}), 32'd0);
      check("rst_rsp_tag", 32'(bus1.rsp_tag), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("rel_ready_before_edge", 32'(bus1.req_ready), 32'd0);
    tick();
    @(negedge clk);
    check("rel_ready_after_edge", 32'(bus1.req_ready), 32'd1);
    check("rel_no_accept", 32'(bus1.rsp_valid), 32'd0);
    tick();

    // basic two-port read, full mask, latency check
    write_reg(5, 'h2A, 16'hA5A5);
    write_reg(5, 'h01, 16'h0FF0);
    issue(5, 'h2A, 'h01, 16'hFFFF, 3);
    @(negedge clk);
    check("t2_read_en_0", 32'(bus1.read_en_0), 32'hFFFF);
    check("t2_lat1_valid", 32'(bus1.rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t2_lat2_valid", 32'(bus1.rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t2_rsp_valid", 32'(bus1.rsp_valid), 32'd1);
    check("t2_mask_0", 32'(bus1.rsp_mask_0), 32'hA5A5);
    check("t2_mask_1", 32'(bus1.rsp_mask_1), 32'h0FF0);
    check("t2_tag", 32'(bus1.rsp_tag), 32'd3);
    tick();
    @(negedge clk);
    check("t2_idle_valid", 32'(bus1.rsp_valid), 32'd0);
    check("t2_idle_ready", 32'(bus1.req_ready), 32'd1);
    tick();

    // partial lane mask; enables for exactly one cycle
    issue(5, 'h2A, 'h01, 16'h00FF, 6);
    @(negedge clk);
    check("t3_read_en_0", 32'(bus1.read_en_0), 32'h00FF);
    check("t3_read_en_1", 32'(bus1.read_en_1), 32'h00FF);
    check("t3_raddr", 32'({bus1.raddr_0, bus1.raddr_1}), 32'({6'h2A, 6'h01}));
    check("t3_warp_sel", 32'(bus1.warp_selector), 32'd5);
    check("t3_req_ready", 32'(bus1.req_ready), 32'd0);
    tick();
    @(negedge clk);
    check("t3_en_off", 32'({bus1.read_en_0, bus1.read_en_1}), 32'd0);
    check("t3_addr_hold", 32'({bus1.raddr_0, bus1.warp_selector}), 32'({6'h2A, 3'd5}));
    tick();
    @(negedge clk);
    check("t3_mask_0", 32'(bus1.rsp_mask_0), 32'h00A5);
    check("t3_mask_1", 32'(bus1.rsp_mask_1), 32'h00F0);
    tick();

    // capture-cycle write to another warp: no forwarding
    issue(5, 'h2A, 'h01, 16'hFFFF, 4);
    tick();
    wr_warp = 3'd4; wr_addr = 6'h2A; wr_data = 16'h3000; wr_en = 16'hF000;
    tick();
    wr_en = '0;
    @(negedge clk);
    check("t4b_valid", 32'(bus1.rsp_valid), 32'd1);
    check("t4b_mask_0", 32'(bus1.rsp_mask_0), 32'hA5A5);
    check("t4b_mask_1", 32'(bus1.rsp_mask_1), 32'h0FF0);
    tick();

    // capture-cycle write to the same warp/addr: forwarded lanes
    issue(5, 'h2A, 'h01, 16'hFFFF, 4);
    tick();
    wr_warp = 3'd5; wr_addr = 6'h2A; wr_data = 16'h3000; wr_en = 16'hF000;
    tick();
    wr_en = '0;
    @(negedge clk);
    check("t4a_valid", 32'(bus1.rsp_valid), 32'd1);
    check("t4a_mask_0", 32'(bus1.rsp_mask_0), 32'h35A5);
    check("t4a_mask_1", 32'(bus1.rsp_mask_1), 32'h0FF0);
    tick();

    // back-pressure: response is a stable snapshot
    rsp_ready = 1'b0;
    issue(5, 'h2A, 'h01, 16'hFFFF, 9);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        wr_warp = 3'd5; wr_addr = 6'h2A; wr_data = 16'h0000; wr_en = 16'hFFFF;
      end else begin
        wr_en = '0;
      end
      @(negedge clk);
      check("t5_valid", 32'(bus1.rsp_valid), 32'd1);
      check("t5_mask_0", 32'(bus1.rsp_mask_0), 32'h35A5);
      check("t5_mask_1", 32'(bus1.rsp_mask_1), 32'h0FF0);
      check("t5_tag", 32'(bus1.rsp_tag), 32'd9);
      check("t5_req_ready", 32'(bus1.req_ready), 32'd0);
      tick();
    end
    wr_en = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t5_valid_at_hs", 32'(bus1.rsp_valid), 32'd1);
    tick();
    @(negedge clk);
    check("t5_after_hs_valid", 32'(bus1.rsp_valid), 32'd0);
    check("t5_after_hs_ready", 32'(bus1.req_ready), 32'd1);
    tick();

    // zero lane mask still walks the FSM and returns zeros
    issue(5, 'h01, 'h01, 16'h0000, 2);
    @(negedge clk);
    check("zm_read_en", 32'({bus1.read_en_0, bus1.read_en_1}), 32'd0);
    wait_rsp(m0, m1, t);
    check("zm_masks", 32'({m0, m1}), 32'd0);
    check("zm_tag", 32'(t), 32'd2);

    // full sweep, both latencies, both ports on the same address
    for (int w = 0; w < NUM_WARPS; w++)
      for (int a = 0; a < NUM_PREGS; a++)
        write_reg(w, a, pat(w, a));
    for (int lat = 1; lat >= 0; lat--) begin
      sel = lat[0];
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int a = 0; a < NUM_PREGS; a++) begin
          issue(w, a, a, 16'hFFFF, a);
          wait_rsp(m0, m1, t);
          check("sweep_mask_0", 32'(m0), 32'(pat(w, a)));
          check("sweep_mask_1", 32'(m1), 32'(pat(w, a)));
          check("sweep_tag", 32'(t), 32'(a % 16));
        end
      end
    end

    // reset during READ discards the transaction
    sel = 1'b1;
    issue(3, 'h10, 'h11, 16'hFFFF, 7);
    @(negedge clk);
    check("mr_in_read", 32'(bus1.read_en_0), 32'hFFFF);
    #1;
    rst = 1'b1;
    #1;
    check("mr_rst_valid", 32'(bus1.rsp_valid), 32'd0);
    check("mr_rst_ready", 32'(bus1.req_ready), 32'd0);
    check("mr_rst_en", 32'(bus1.read_en_0), 32'd0);
    check("mr_rst_masks", 32'({bus1.rsp_mask_0, bus1.rsp_mask_1}), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("mr_no_rsp", 32'(bus1.rsp_valid), 32'd0);
      check("mr_ready", 32'(bus1.req_ready), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
